// File: rtl/rd_pkt_sender_if.sv
// Descriptor, SRAM read and output-stream signals of one rd_pkt_sender port.
// master = the sender itself; slave = arbiter, SRAM and downstream port.
interface rd_pkt_sender_if #(
   parameter int data_width     = 64,
   parameter int address_width  = 12,
   parameter int des_port_width = 7,
   parameter int priority_width = 3
);
   logic                      desc_vld;
   logic                      desc_rdy;
   logic [address_width-1:0]  desc_addr;
   logic [des_port_width-1:0] desc_len;
   logic [priority_width-1:0] desc_pri;

   logic                      rd_request;
   logic [address_width-1:0]  address_read;
   logic                      rd_grant;
   logic [data_width-1:0]     data_read;

   logic                      rd_sop;
   logic                      rd_eop;
   logic                      rd_vld;
   logic [data_width-1:0]     rd_data;

   logic                      pkt_done;
   logic [address_width-1:0]  done_addr;
   logic [des_port_width-1:0] done_len;
   logic [priority_width-1:0] done_pri;
   logic                      busy;

   modport master (
      input  desc_vld, desc_addr, desc_len, desc_pri, rd_grant, data_read,
      output desc_rdy, rd_request, address_read, rd_sop, rd_eop, rd_vld, rd_data,
             pkt_done, done_addr, done_len, done_pri, busy
   );

   modport slave (
      output desc_vld, desc_addr, desc_len, desc_pri, rd_grant, data_read,
      input  desc_rdy, rd_request, address_read, rd_sop, rd_eop, rd_vld, rd_data,
             pkt_done, done_addr, done_len, done_pri, busy
   );
endinterface

// File: rtl/rd_pkt_sender.sv
// Per-port read-side packet sender: fetches one packet's words from shared SRAM
// through a granted request, streams them out with sop/eop and reports completion.
module rd_pkt_sender #(
   parameter int data_width     = 64,
   parameter int address_width  = 12,
   parameter int des_port_width = 7,
   parameter int priority_width = 3,
   parameter int rd_lat         = 1
) (
   input logic            clk,
   input logic            rst_n,
   rd_pkt_sender_if.master bus
);

   localparam int LAST = rd_lat - 1;
   localparam logic [des_port_width-1:0] LEN_ONE = des_port_width'(1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t state, state_nxt;

   logic [address_width-1:0]  base_addr, cur_addr;
   logic [des_port_width-1:0] base_len, remaining, len_eff;
   logic [priority_width-1:0] base_pri;
   logic                      first_word;

   logic [rd_lat-1:0] pipe_vld, pipe_sop, pipe_eop;

   logic                      out_vld, out_sop, out_eop, done_q;
   logic [data_width-1:0]     out_data;
   logic [address_width-1:0]  done_addr_q;
   logic [des_port_width-1:0] done_len_q;
   logic [priority_width-1:0] done_pri_q;

   logic accept, fire;

   assign len_eff = (bus.desc_len == '0) ? LEN_ONE : bus.desc_len;
   assign accept  = (state == IDLE)  && bus.desc_vld;
   assign fire    = (state == FETCH) && bus.rd_grant;

   // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.desc_vld) state_nxt = FETCH;
         FETCH:   if (bus.rd_grant && remaining == LEN_ONE) state_nxt = DRAIN;
         DRAIN:   if (out_vld && out_eop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_addr  <= '0;
         base_len   <= '0;
         base_pri   <= '0;
         cur_addr   <= '0;
         remaining  <= '0;
         first_word <= 1'b0;
      end else if (accept) begin
         base_addr  <= bus.desc_addr;
         base_len   <= len_eff;
         base_pri   <= bus.desc_pri;
         cur_addr   <= bus.desc_addr;
         remaining  <= len_eff;
         first_word <= 1'b1;
      end else if (fire) begin
         cur_addr   <= cur_addr + 1'b1;
         remaining  <= remaining - LEN_ONE;
         first_word <= 1'b0;
      end
   end

   // Token shift mirrors the SRAM latency so data_read is sampled exactly when valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         pipe_sop <= '0;
         pipe_eop <= '0;
      end else begin
         pipe_vld[0] <= fire;
         pipe_sop[0] <= fire && first_word;
         pipe_eop[0] <= fire && (remaining == LEN_ONE);
         for (int i = 1; i < rd_lat; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_sop[i] <= pipe_sop[i-1];
            pipe_eop[i] <= pipe_eop[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld     <= 1'b0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_data    <= '0;
         done_q      <= 1'b0;
         done_addr_q <= '0;
         done_len_q  <= '0;
         done_pri_q  <= '0;
      end else begin
         out_vld <= pipe_vld[LAST];
         out_sop <= pipe_vld[LAST] && pipe_sop[LAST];
         out_eop <= pipe_vld[LAST] && pipe_eop[LAST];
         done_q  <= pipe_vld[LAST] && pipe_eop[LAST];
         if (pipe_vld[LAST]) out_data <= bus.data_read;
         if (pipe_vld[LAST] && pipe_eop[LAST]) begin
            done_addr_q <= base_addr;
            done_len_q  <= base_len;
            done_pri_q  <= base_pri;
         end
      end
   end

   assign bus.desc_rdy     = (state == IDLE);
   assign bus.busy         = (state != IDLE);
   assign bus.rd_request   = (state == FETCH);
   assign bus.address_read = (state == FETCH) ? cur_addr : '0;
   assign bus.rd_vld       = out_vld;
   assign bus.rd_sop       = out_sop;
   assign bus.rd_eop       = out_eop;
   assign bus.rd_data      = out_data;
   assign bus.pkt_done     = done_q;
   assign bus.done_addr    = done_addr_q;
   assign bus.done_len     = done_len_q;
   assign bus.done_pri     = done_pri_q;

endmodule
